// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause encoding and a
// saturating event-counter helper.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_HOLD      = 2'd1,
        S_RUN       = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_RESET  = 2'd0,
        CAUSE_BUTTON = 2'd1,
        CAUSE_BREAK  = 2'd2,
        CAUSE_LOCK   = 2'd3
    } cause_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Multi-flop synchroniser followed by a counter debouncer; the debounced level only
// follows the input after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module sync_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter logic        RESET_VAL       = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic db_o,
    output logic rise_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   db_prev_q;
    logic                   in_s;

    assign in_s = sync_q[SYNC_STAGES-1];

    // Any cycle where the input agrees with the debounced level restarts the count.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (in_s != db_q) begin
            if (cnt_q == CntLast) begin
                db_d = in_s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q    <= {SYNC_STAGES{RESET_VAL}};
            cnt_q     <= '0;
            db_q      <= RESET_VAL;
            db_prev_q <= RESET_VAL;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            db_prev_q <= db_q;
        end
    end

    assign db_o   = db_q;
    assign rise_o = db_q & ~db_prev_q;

endmodule

// File: rtl/reset_sequencer.sv
// System reset sequencer: merges button, UART break and clock-lock status into a
// registered reset with a guaranteed minimum width, and records the last reset cause.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES     = 1024,
    parameter int unsigned BREAK_CYCLES    = 10_000_000
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       uart_rxd,
    input  logic       mmcm_locked,
    output logic       sys_reset,
    output logic       seq_busy,
    output logic [1:0] cause,
    output logic [7:0] reset_count
);

    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam int unsigned BrkW = $clog2(BREAK_CYCLES + 1);
    localparam logic [BrkW-1:0] BrkMax  = BrkW'(BREAK_CYCLES);
    localparam logic [BrkW-1:0] BrkLast = BrkW'(BREAK_CYCLES - 1);

    logic btn_db, btn_press;

    sync_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (1'b0)
    ) u_btn (
        .clk_i (clkin),
        .rst_i (reset),
        .raw_i (btn_raw),
        .db_o  (btn_db),
        .rise_o(btn_press)
    );

    logic [SYNC_STAGES-1:0] rxd_sync_q, lock_sync_q;
    logic                   rxd_s, locked_s;

    always_ff @(posedge clkin) begin
        if (reset) begin
            rxd_sync_q  <= '1;
            lock_sync_q <= '0;
        end else begin
            rxd_sync_q  <= {rxd_sync_q[SYNC_STAGES-2:0], uart_rxd};
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], mmcm_locked};
        end
    end

    assign rxd_s    = rxd_sync_q[SYNC_STAGES-1];
    assign locked_s = lock_sync_q[SYNC_STAGES-1];

    // Break detector: fires once per low period; disarmed until the line returns high.
    logic [BrkW-1:0] brk_cnt_q, brk_cnt_d;
    logic            brk_armed_q, brk_armed_d;
    logic            brk_req;

    assign brk_req = brk_armed_q & ~rxd_s & (brk_cnt_q == BrkLast);

    always_comb begin
        brk_cnt_d   = brk_cnt_q;
        brk_armed_d = brk_armed_q;
        if (rxd_s) begin
            brk_cnt_d   = '0;
            brk_armed_d = 1'b1;
        end else begin
            if (brk_cnt_q != BrkMax) begin
                brk_cnt_d = brk_cnt_q + 1'b1;
            end
            if (brk_req) begin
                brk_armed_d = 1'b0;
            end
        end
    end

    state_t           state_q, state_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    cause_t           cause_q, cause_d;
    logic [7:0]       count_q, count_d;
    logic             rst_out_q;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        cause_d    = cause_q;
        count_d    = count_q;
        unique case (state_q)
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (btn_db) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HoldLast) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                // Simultaneous events collapse into one, highest priority wins.
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    cause_d = CAUSE_LOCK;
                    count_d = sat_inc8(count_q);
                end else if (btn_press) begin
                    state_d = S_HOLD;
                    cause_d = CAUSE_BUTTON;
                    count_d = sat_inc8(count_q);
                end else if (brk_req) begin
                    state_d = S_HOLD;
                    cause_d = CAUSE_BREAK;
                    count_d = sat_inc8(count_q);
                end
            end
            default: state_d = S_WAIT_LOCK;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= S_WAIT_LOCK;
            hold_cnt_q  <= '0;
            cause_q     <= CAUSE_RESET;
            count_q     <= '0;
            rst_out_q   <= 1'b1;
            brk_cnt_q   <= '0;
            brk_armed_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cause_q     <= cause_d;
            count_q     <= count_d;
            rst_out_q   <= (state_d != S_RUN);
            brk_cnt_q   <= brk_cnt_d;
            brk_armed_q <= brk_armed_d;
        end
    end

    assign sys_reset   = rst_out_q;
    assign seq_busy    = rst_out_q;
    assign cause       = cause_q;
    assign reset_count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with shortened timing parameters; expected
// values are hand-computed cycle counts from the synchroniser/debounce/hold latencies.
module tb_reset_sequencer;

    logic       clkin;
    logic       reset;
    logic       btn_raw;
    logic       uart_rxd;
    logic       mmcm_locked;
    logic       sys_reset;
    logic       seq_busy;
    logic [1:0] cause;
    logic [7:0] reset_count;

    int checks   = 0;
    int failures = 0;

    reset_sequencer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8),
        .HOLD_CYCLES    (16),
        .BREAK_CYCLES   (32)
    ) dut (
        .clkin      (clkin),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .uart_rxd   (uart_rxd),
        .mmcm_locked(mmcm_locked),
        .sys_reset  (sys_reset),
        .seq_busy   (seq_busy),
        .cause      (cause),
        .reset_count(reset_count)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // Returns 1 ns after the n-th rising edge so inputs change and outputs are sampled
    // away from the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic rst_e, input logic [1:0] cause_e,
                              input logic [7:0] cnt_e);
        check({tag, ".sys_reset"}, {31'd0, sys_reset}, {31'd0, rst_e});
        check({tag, ".seq_busy"}, {31'd0, seq_busy}, {31'd0, rst_e});
        check({tag, ".cause"}, {30'd0, cause}, {30'd0, cause_e});
        check({tag, ".count"}, {24'd0, reset_count}, {24'd0, cnt_e});
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (sys_reset !== 1'b0 && n < 200) begin
            tick(1);
            n++;
        end
        check({tag, ".wait_run"}, {31'd0, sys_reset}, 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        btn_raw     = 1'b0;
        uart_rxd    = 1'b1;
        mmcm_locked = 1'b1;

        // 1: reset values, then release 19 cycles after reset deasserts
        tick(5);
        check_outs("rst_vals", 1'b1, 2'd0, 8'd0);
        reset = 1'b0;
        tick(18);
        check("t1_edge18", {31'd0, sys_reset}, 32'd1);
        tick(1);
        check_outs("t1_edge19", 1'b0, 2'd0, 8'd0);

        // 2: short glitch ignored, 12-cycle press resets 11 cycles after rising
        btn_raw = 1'b1;
        tick(5);
        btn_raw = 1'b0;
        tick(20);
        check_outs("t2_glitch", 1'b0, 2'd0, 8'd0);
        btn_raw = 1'b1;
        tick(10);
        check("t2_edge10", {31'd0, sys_reset}, 32'd0);
        tick(1);
        check_outs("t2_edge11", 1'b1, 2'd1, 8'd1);
        tick(1);
        btn_raw = 1'b0;
        wait_run("t2");

        // 3: long press extends hold until 16 cycles after debounced release
        btn_raw = 1'b1;
        tick(11);
        check_outs("t3_press", 1'b1, 2'd1, 8'd2);
        tick(89);
        btn_raw = 1'b0;
        tick(25);
        check("t3_edge125", {31'd0, sys_reset}, 32'd1);
        tick(1);
        check_outs("t3_edge126", 1'b0, 2'd1, 8'd2);

        // Fresh reset so break counts start from zero
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(19);
        check_outs("t4_rerun", 1'b0, 2'd0, 8'd0);

        // 4: UART break threshold, no retrigger while held low, rearm after high
        uart_rxd = 1'b0;
        tick(31);
        uart_rxd = 1'b1;
        tick(10);
        check_outs("t4_short", 1'b0, 2'd0, 8'd0);
        uart_rxd = 1'b0;
        tick(33);
        check("t4_edge33", {31'd0, sys_reset}, 32'd0);
        tick(1);
        check_outs("t4_brk1", 1'b1, 2'd2, 8'd1);
        tick(200);
        check_outs("t4_held", 1'b0, 2'd2, 8'd1);
        uart_rxd = 1'b1;
        tick(5);
        uart_rxd = 1'b0;
        tick(33);
        check("t4_brk2_pre", {31'd0, sys_reset}, 32'd0);
        tick(1);
        check_outs("t4_brk2", 1'b1, 2'd2, 8'd2);
        uart_rxd = 1'b1;
        wait_run("t4");

        // 5: lock loss in RUN, lock loss in HOLD, reset in HOLD
        mmcm_locked = 1'b0;
        tick(2);
        check("t5_lock_pre", {31'd0, sys_reset}, 32'd0);
        tick(1);
        check_outs("t5_lock", 1'b1, 2'd3, 8'd3);
        mmcm_locked = 1'b1;
        tick(8);
        mmcm_locked = 1'b0;
        tick(10);
        check_outs("t5_hold_loss", 1'b1, 2'd3, 8'd3);
        mmcm_locked = 1'b1;
        tick(18);
        check("t5_relock18", {31'd0, sys_reset}, 32'd1);
        tick(1);
        check_outs("t5_relock19", 1'b0, 2'd3, 8'd3);
        mmcm_locked = 1'b0;
        tick(3);
        mmcm_locked = 1'b1;
        tick(8);
        check_outs("t5_in_hold", 1'b1, 2'd3, 8'd4);
        reset = 1'b1;
        tick(1);
        check_outs("t5_mid_reset", 1'b1, 2'd0, 8'd0);
        reset = 1'b0;
        tick(18);
        check("t5_rel18", {31'd0, sys_reset}, 32'd1);
        tick(1);
        check_outs("t5_rel19", 1'b0, 2'd0, 8'd0);

        // 6: button and break land on the same cycle -> one event, button wins
        uart_rxd = 1'b0;
        tick(23);
        btn_raw = 1'b1;
        tick(10);
        check("t6_pre", {31'd0, sys_reset}, 32'd0);
        tick(1);
        check_outs("t6_both", 1'b1, 2'd1, 8'd1);
        tick(6);
        btn_raw  = 1'b0;
        uart_rxd = 1'b1;
        wait_run("t6");
        check_outs("t6_after", 1'b0, 2'd1, 8'd1);

        // 6: saturation of the event counter
        for (int i = 0; i < 260; i++) begin
            mmcm_locked = 1'b0;
            tick(3);
            mmcm_locked = 1'b1;
            wait_run("t6_sat_loop");
            if (i == 253) begin
                check("t6_count_255", {24'd0, reset_count}, 32'd255);
            end
        end
        check_outs("t6_sat", 1'b0, 2'd3, 8'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
